// File: rtl/bayer_port_arbiter_pkg.sv
// Shared types and constants for the Bayer frame-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding (which doubles as the owner encoding),
// frame geometry, bus widths and the per-client request bundle.
package bayer_port_arbiter_pkg;

  // Frame geometry: 128x128 Bayer frame, linear address row*128+col.
  localparam int FRAME_W = 128;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;

  // Beat counter width; large enough to count up to a 64-beat burst.
  localparam int BEAT_W  = 6;

  // The state value is driven straight onto the owner output, so the
  // encodings below are the externally visible owner codes as well.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_C0   = 2'b01;
  localparam logic [1:0] OWNER_C1   = 2'b10;

  // One client's request bundle, used to mux the owning client onto the
  // memory port.
  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } client_req_t;

endpackage

// File: rtl/bayer_port_arbiter_pick.sv
// Two-input round-robin picker used when the port is idle.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; pick is meaningful only while any is high.
//
// Ports:
//   req0, req1 : client requests
//   ptr        : round-robin pointer, 0 favours client 0, 1 favours client 1
//   pick       : chosen client (0 or 1)
//   any        : at least one client is requesting
module bayer_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic pick,
  output logic any
);

  always_comb begin
    any = req0 | req1;
    // With a single requester the pointer is irrelevant; with two, the
    // pointer breaks the tie. With none, pick defaults to client 0.
    if (req0 && req1) begin
      pick = ptr;
    end else begin
      pick = req1;
    end
  end

endmodule

// File: rtl/bayer_port_arbiter.sv
// Burst-locking round-robin arbiter sharing one frame-memory read port between two interpolation engines.
// Latency: grant combinational with request while owning; cN_rvalid 1 cycle after cN_gnt; rdata = mem_rdata.
// Backpressure: a client stalls by holding req until gnt; a non-requesting owner keeps the port (burst lock).
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   c0_req/c0_addr/c0_last           client 0 (green engine) beat request
//   c0_gnt, c0_rvalid                client 0 beat accepted / read data valid
//   c1_*                             same for client 1 (R/B engine)
//   rdata                            shared read data, qualified by cN_rvalid
//   mem_en, mem_addr, mem_rdata      frame-memory read port (data 1 cycle after mem_en)
//   owner                            00 idle, 01 client 0, 10 client 1
module bayer_port_arbiter
  import bayer_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              c0_req,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic              c0_last,
  output logic              c0_gnt,
  output logic              c0_rvalid,

  input  logic              c1_req,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic              c1_last,
  output logic              c1_gnt,
  output logic              c1_rvalid,

  output logic [DATA_W-1:0] rdata,

  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [1:0]        owner
);

  // The beat counter holds the number of beats already granted in the
  // current ownership, so the beat being granted is beat_q+1. A grant
  // while beat_q == MAX_BURST-1 is therefore beat number MAX_BURST.
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  arb_state_t        state_q, state_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;
  logic              ptr_q,   ptr_d;

  logic              pick;
  logic              any_req;

  client_req_t       act;        // request bundle of the owning client
  logic              act_is_c1;  // owning client is client 1
  logic              oth_req;    // the non-owning client is requesting
  logic              act_gnt;    // a beat is accepted this cycle

  bayer_arb_pick u_pick (
    .req0 (c0_req),
    .req1 (c1_req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any_req)
  );

  // Steer the owning client's request onto a common bundle so the FSM
  // body is written once for both OWN states.
  always_comb begin
    act_is_c1 = (state_q == ST_OWN1);
    if (act_is_c1) begin
      act     = '{req: c1_req, addr: c1_addr, last: c1_last};
      oth_req = c0_req;
    end else begin
      act     = '{req: c0_req, addr: c0_addr, last: c0_last};
      oth_req = c1_req;
    end
  end

  // Next-state, beat counter and pointer.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    act_gnt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Arbitration cycle only; no beat is issued from IDLE.
        if (any_req) begin
          state_d = pick ? ST_OWN1 : ST_OWN0;
        end
      end

      ST_OWN0, ST_OWN1: begin
        act_gnt = act.req;
        // Without a request the owner keeps the port and the count holds.
        if (act.req) begin
          if (act.last || (beat_q == LAST_BEAT)) begin
            // Release: either the client ended its burst or it hit the
            // burst limit. A forced release is silent; the client simply
            // re-requests and carries on with its next address later.
            beat_d = '0;
            ptr_d  = ~act_is_c1;
            if (oth_req) begin
              // Hand straight over, no idle bubble.
              state_d = act_is_c1 ? ST_OWN0 : ST_OWN1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  assign c0_gnt   = act_gnt & ~act_is_c1;
  assign c1_gnt   = act_gnt &  act_is_c1;
  assign mem_en   = act_gnt;
  // Address is passed through untouched while a beat is issued and held
  // at zero otherwise.
  assign mem_addr = act_gnt ? act.addr : '0;
  assign rdata    = mem_rdata;
  assign owner    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      ptr_q     <= 1'b0;
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      ptr_q     <= ptr_d;
      // Memory returns data one cycle after mem_en, so the valid strobe
      // is simply the grant delayed by one cycle. Grants are exclusive,
      // hence the two strobes are too.
      c0_rvalid <= c0_gnt;
      c1_rvalid <= c1_gnt;
    end
  end

endmodule

// File: tb/tb_bayer_port_arbiter.sv
// Self-checking bench for bayer_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of ownership, bursts and round-robin fairness.
// Clients are modelled as beat queues that advance only when granted.
module tb_bayer_port_arbiter;

  localparam int MAXB = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_req, c0_last, c1_req, c1_last;
  logic [13:0] c0_addr, c1_addr;
  logic        c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
  logic [7:0]  rdata;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [1:0]  owner;

  int total = 0;
  int bad   = 0;

  // Reference model: owner as client id + 1 (0 = nobody), beats served in
  // the current ownership, client favoured on a tie, and last cycle's grants.
  int          m_owner, m_beats, m_fav;
  bit          m_rv0, m_rv1, m_pend;
  logic [13:0] m_pend_addr;

  // Client beat queues and request pauses.
  logic [13:0] q0a[$], q1a[$];
  bit          q0l[$], q1l[$];
  int          pause0, pause1;

  // Observed DUT trace, one entry per tick.
  int          tr_owner[$];
  bit          tr_g0[$], tr_g1[$], tr_rv0[$], tr_rv1[$];
  logic [13:0] tr_addr[$];

  bayer_port_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_last(c0_last), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_last(c1_last), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]};
  endfunction

  task automatic model_reset();
    m_owner = 0; m_beats = 0; m_fav = 0;
    m_rv0 = 0; m_rv1 = 0; m_pend = 0; m_pend_addr = '0;
    q0a.delete(); q0l.delete(); q1a.delete(); q1l.delete();
    pause0 = 0; pause1 = 0;
  endtask

  task automatic clear_trace();
    tr_owner.delete(); tr_g0.delete(); tr_g1.delete();
    tr_rv0.delete(); tr_rv1.delete(); tr_addr.delete();
  endtask

  task automatic enqueue(input int c, input int len, input int base);
    for (int i = 0; i < len; i++) begin
      logic [13:0] a;
      a = (base < 0) ? 14'($urandom_range(0, 16383)) : 14'(base + i);
      if (c == 0) begin q0a.push_back(a); q0l.push_back(i == len - 1); end
      else        begin q1a.push_back(a); q1l.push_back(i == len - 1); end
    end
  endtask

  // One clock cycle: entered at posedge+1, drives inputs, checks at
  // posedge+3, advances the model, returns at the next posedge+1.
  task automatic tick(input string tag);
    bit          e_g0, e_g1, e_en, lst, oreq;
    logic [13:0] e_addr;
    int          g;
    c0_req  = (q0a.size() != 0) && (pause0 == 0);
    c0_addr = c0_req ? q0a[0] : 14'($urandom);
    c0_last = c0_req ? q0l[0] : 1'($urandom);
    c1_req  = (q1a.size() != 0) && (pause1 == 0);
    c1_addr = c1_req ? q1a[0] : 14'($urandom);
    c1_last = c1_req ? q1l[0] : 1'($urandom);
    mem_rdata = m_pend ? pix(m_pend_addr) : 8'($urandom);
    #2;
    e_g0   = (m_owner == 1) && c0_req;
    e_g1   = (m_owner == 2) && c1_req;
    e_en   = e_g0 | e_g1;
    e_addr = e_g0 ? c0_addr : (e_g1 ? c1_addr : 14'd0);

    total++;
    if (owner !== 2'(m_owner)) begin
      bad++; $display("FAIL %s owner: got %0d want %0d", tag, owner, m_owner);
    end
    total++;
    if ({c0_gnt, c1_gnt} !== {e_g0, e_g1}) begin
      bad++; $display("FAIL %s gnt: got %b%b want %b%b", tag, c0_gnt, c1_gnt, e_g0, e_g1);
    end
    total++;
    if ({mem_en, mem_addr} !== {e_en, e_addr}) begin
      bad++; $display("FAIL %s mem: got en=%b addr=%0d want en=%b addr=%0d", tag, mem_en, mem_addr, e_en, e_addr);
    end
    total++;
    if ({c0_rvalid, c1_rvalid} !== {m_rv0, m_rv1}) begin
      bad++; $display("FAIL %s rvalid: got %b%b want %b%b", tag, c0_rvalid, c1_rvalid, m_rv0, m_rv1);
    end
    if (m_rv0 || m_rv1) begin
      total++;
      if (rdata !== pix(m_pend_addr)) begin
        bad++; $display("FAIL %s rdata: got %h want %h", tag, rdata, pix(m_pend_addr));
      end
    end
    total++;
    if ((c0_gnt && c1_gnt) || (mem_en !== (c0_gnt | c1_gnt)) || (c0_rvalid && c1_rvalid)) begin
      bad++; $display("FAIL %s invariant: gnt=%b%b mem_en=%b rvalid=%b%b want exclusive gnt, mem_en=or(gnt), exclusive rvalid",
                      tag, c0_gnt, c1_gnt, mem_en, c0_rvalid, c1_rvalid);
    end

    tr_owner.push_back(int'(owner)); tr_g0.push_back(c0_gnt); tr_g1.push_back(c1_gnt);
    tr_rv0.push_back(c0_rvalid); tr_rv1.push_back(c1_rvalid); tr_addr.push_back(mem_addr);

    // Model: data for a beat returns next cycle; ownership by the rules of
    // round-robin arbitration, burst release and the beat limit.
    m_rv0 = e_g0; m_rv1 = e_g1; m_pend = e_en; m_pend_addr = e_addr;
    if (m_owner == 0) begin
      if (c0_req && c1_req) m_owner = m_fav + 1;
      else if (c0_req)      m_owner = 1;
      else if (c1_req)      m_owner = 2;
    end else if (e_en) begin
      g    = m_owner - 1;
      lst  = (g == 0) ? c0_last : c1_last;
      oreq = (g == 0) ? c1_req : c0_req;
      m_beats++;
      if (lst || m_beats == MAXB) begin
        m_fav   = 1 - g;
        m_beats = 0;
        m_owner = oreq ? (2 - g) : 0;
      end
    end
    if (e_g0) begin void'(q0a.pop_front()); void'(q0l.pop_front()); end
    if (e_g1) begin void'(q1a.pop_front()); void'(q1l.pop_front()); end
    if (pause0 > 0) pause0--;
    if (pause1 > 0) pause1--;
    @(posedge clk); #1;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((q0a.size() != 0 || q1a.size() != 0 || m_owner != 0) && n < budget) begin
      tick(tag); n++;
    end
    total++;
    if (q0a.size() != 0 || q1a.size() != 0 || m_owner != 0) begin
      bad++; $display("FAIL %s timeout: still busy after %0d cycles, want idle", tag, n);
    end
    tick(tag);  // collect rvalid of the final beat
  endtask

  // Asynchronous reset asserted mid-cycle with both clients requesting.
  task automatic reset_dut(input string tag);
    rst = 1'b1;
    c0_req = 1'b1; c1_req = 1'b1;
    c0_addr = 14'($urandom); c1_addr = 14'($urandom);
    model_reset();
    #2;
    total++;
    if ({owner, c0_gnt, c1_gnt, mem_en, mem_addr, c0_rvalid, c1_rvalid} !== 21'd0) begin
      bad++; $display("FAIL %s in_reset: owner=%b gnt=%b%b mem_en=%b addr=%0d rvalid=%b%b want all 0",
                      tag, owner, c0_gnt, c1_gnt, mem_en, mem_addr, c0_rvalid, c1_rvalid);
    end
    @(posedge clk); #1;
    total++;
    if ({owner, mem_en, c0_rvalid, c1_rvalid} !== 5'd0) begin
      bad++; $display("FAIL %s held_reset: owner=%b mem_en=%b rvalid=%b%b want 0", tag, owner, mem_en, c0_rvalid, c1_rvalid);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut("reset");
  endtask

  task automatic test_single_burst();
    logic [13:0] ea [4] = '{14'd129, 14'd385, 14'd257, 14'd130};
    clear_trace();
    for (int i = 0; i < 4; i++) begin q0a.push_back(ea[i]); q0l.push_back(i == 3); end
    run_until_idle("single", 20);
    total++;
    if (tr_owner.size() != 6) begin
      bad++; $display("FAIL single len: got %0d cycles want 6", tr_owner.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (tr_owner[i] != ((i >= 1 && i <= 4) ? 1 : 0) || tr_g0[i] != (i >= 1 && i <= 4)) begin
          bad++; $display("FAIL single cyc%0d: owner=%0d gnt0=%b", i, tr_owner[i], tr_g0[i]);
        end
        if (i >= 1 && i <= 4) begin
          total++;
          if (tr_addr[i] !== ea[i-1]) begin
            bad++; $display("FAIL single addr%0d: got %0d want %0d", i, tr_addr[i], ea[i-1]);
          end
        end
        total++;
        if (tr_rv0[i] != (i >= 2)) begin
          bad++; $display("FAIL single rvalid%0d: got %b want %b", i, tr_rv0[i], i >= 2);
        end
      end
    end
  endtask

  task automatic test_contention();
    int eo [8] = '{0, 1, 1, 1, 2, 2, 2, 0};
    reset_dut("contention_rst");
    clear_trace();
    enqueue(0, 3, 100); enqueue(1, 3, 200);
    run_until_idle("contention", 20);
    total++;
    if (tr_owner.size() != 8) begin
      bad++; $display("FAIL contention len: got %0d want 8", tr_owner.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (tr_owner[i] != eo[i]) begin
          bad++; $display("FAIL contention owner%0d: got %0d want %0d", i, tr_owner[i], eo[i]);
        end
      end
    end
    clear_trace();
    enqueue(0, 3, 300); enqueue(1, 3, 400);
    run_until_idle("contention2", 20);
    total++;
    if (tr_owner.size() < 2 || tr_owner[1] != 1) begin
      bad++; $display("FAIL contention2 first: got owner %0d want 1", (tr_owner.size() > 1) ? tr_owner[1] : -1);
    end
  endtask

  task automatic test_lock();
    int n0 = 0;
    clear_trace();
    enqueue(0, 6, 500);
    tick("lock");
    enqueue(1, 2, 600);
    tick("lock"); tick("lock");
    pause0 = 5;
    run_until_idle("lock", 40);
    for (int i = 0; i < tr_g0.size(); i++) if (tr_g0[i]) n0++;
    total++;
    if (n0 != 6) begin bad++; $display("FAIL lock c0_beats: got %0d want 6", n0); end
    total++;
    if (tr_owner.size() != 15) begin
      bad++; $display("FAIL lock len: got %0d want 15", tr_owner.size());
    end else begin
      for (int i = 3; i <= 7; i++) begin
        total++;
        if (tr_owner[i] != 1 || tr_g1[i] || tr_g0[i]) begin
          bad++; $display("FAIL lock hold%0d: owner=%0d gnt=%b%b want 1 00", i, tr_owner[i], tr_g0[i], tr_g1[i]);
        end
      end
      total++;
      if (tr_owner[12] != 2 || !tr_g1[12]) begin
        bad++; $display("FAIL lock handover: owner=%0d gnt1=%b want 2 1", tr_owner[12], tr_g1[12]);
      end
    end
  endtask

  task automatic test_forced_release();
    int k = -1, n1 = 0;
    clear_trace();
    enqueue(1, 70, 1000);
    tick("forced");
    enqueue(0, 2, 2000);
    run_until_idle("forced", 200);
    for (int i = 1; i < tr_owner.size(); i++) if (k < 0 && tr_owner[i] == 1) k = i;
    for (int i = 0; i < k; i++) if (tr_g1[i]) n1++;
    total++;
    if (k != 65 || n1 != MAXB) begin
      bad++; $display("FAIL forced handover: c1 beats=%0d at cycle %0d want %0d at 65", n1, k, MAXB);
    end
    total++;
    if (tr_addr.size() < 68 || tr_addr[67] !== 14'd1064 || !tr_g1[67]) begin
      bad++; $display("FAIL forced resume: got addr %0d want 1064", (tr_addr.size() > 67) ? tr_addr[67] : 14'd0);
    end
  endtask

  task automatic test_reset_mid_burst();
    enqueue(0, 4, 700);
    run_until_idle("rstmid_pre", 20);   // leaves the pointer favouring c1
    clear_trace();
    enqueue(0, 4, 800);
    tick("rstmid"); tick("rstmid");    // arbitration + beat 1
    reset_dut("rstmid_rst");           // reset during beat 2
    clear_trace();
    tick("rstmid_after");
    total++;
    if (tr_rv0[0] || tr_rv1[0]) begin
      bad++; $display("FAIL rstmid rvalid_after: got %b%b want 00", tr_rv0[0], tr_rv1[0]);
    end
    clear_trace();
    enqueue(0, 1, 900); enqueue(1, 1, 950);
    run_until_idle("rstmid_arb", 20);
    total++;
    if (tr_owner.size() < 2 || tr_owner[1] != 1) begin
      bad++; $display("FAIL rstmid favour: got owner %0d want 1", (tr_owner.size() > 1) ? tr_owner[1] : -1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if (q0a.size() == 0 && $urandom_range(0, 3) == 0)
        enqueue(0, ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 6), -1);
      if (q1a.size() == 0 && $urandom_range(0, 3) == 0)
        enqueue(1, ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 6), -1);
      if (pause0 == 0 && $urandom_range(0, 15) == 0) pause0 = $urandom_range(1, 4);
      if (pause1 == 0 && $urandom_range(0, 15) == 0) pause1 = $urandom_range(1, 4);
      tick("random");
    end
    run_until_idle("random_drain", 400);
  endtask

  initial begin
    rst = 1'b1;
    c0_req = 0; c1_req = 0; c0_last = 0; c1_last = 0;
    c0_addr = '0; c1_addr = '0; mem_rdata = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_single_burst();
    test_contention();
    test_lock();
    test_forced_release();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
